rangefinder_vga_axil_regs: RTL
==============================

// Module: rangefinder_vga_axil_regs
// PURPOSE
// AXI4-Lite slave register file for the rangefinder VGA peripheral. Terminates the PS/BFM master
// port, holds four fully read/write 32-bit registers at offsets 0x0/0x4/0x8/0xC and exports
// them to the VGA/rangefinder datapath. It sits directly downstream of the AXI4-Lite master.
// PARAMETERS
// DATA_WIDTH  32  AXI data width; only 32 is supported.
// ADDR_WIDTH  4   AXI address width; bits [3:2] select the register and bits [1:0] are ignored.
// PORTS
// ACLK          in   1   Sole clock; everything samples on the rising edge.
// ARESETN       in   1   Asynchronous, active-low reset.
// S_AXI_AWADDR  in   4   Write address.
// S_AXI_AWPROT  in   3   Write protection; ignored.
// S_AXI_AWVALID in   1   Write address valid.
// S_AXI_AWREADY out  1   Write address accepted.
// S_AXI_WDATA   in   32  Write data.
// S_AXI_WSTRB   in   4   Byte enables.
// S_AXI_WVALID  in   1   Write data valid.
// S_AXI_WREADY  out  1   Write data accepted.
// S_AXI_BRESP   out  2   Write response; always 2'b00 (OKAY).
// S_AXI_BVALID  out  1   Write response valid.
// S_AXI_BREADY  in   1   Master ready for the write response.
// S_AXI_ARADDR  in   4   Read address.
// S_AXI_ARPROT  in   3   Read protection; ignored.
// S_AXI_ARVALID in   1   Read address valid.
// S_AXI_ARREADY out  1   Read address accepted.
// S_AXI_RDATA   out  32  Read data.
// S_AXI_RRESP   out  2   Read response; always 2'b00 (OKAY).
// S_AXI_RVALID  out  1   Read data valid.
// S_AXI_RREADY  in   1   Master ready for read data.
// REG0..REG3    out  32  Current register contents, driven straight from the flops.
// BEHAVIOUR
// - Reset (ARESETN=0, asynchronous): REG0..3=0; all READY and VALID outputs=0; RDATA=0; BRESP=RRESP=0.
// - Write FSM states:
//   - W_IDLE: AWREADY and WREADY pulse together for 1 cycle when AWVALID & WVALID & !BVALID.
//   - If AW and W arrive on different cycles, the slave waits until both are high; there is no
//     address-only latch.
// - Write commit happens on the acceptance edge.
//   - For each byte n with WSTRB[n]=1: REGsel[8n+7:8n] <= WDATA[8n+7:8n]. Other bytes are held.
// - W_RESP: BVALID=1 from the cycle after acceptance. It is held until BREADY=1, then clears on that
//   edge and the FSM returns to W_IDLE. No new write is accepted while BVALID=1.
// - Read FSM:
//   - ARREADY pulses for 1 cycle when ARVALID & !RVALID & !ARREADY.
//   - RDATA is registered on that edge; RVALID=1 the next cycle and is held until RREADY.
//   - RDATA is stable while RVALID=1.
// - Latency: write accept to BVALID = 1 cycle; ARVALID to RVALID = 2 cycles minimum.
// - Read and write are independent and may be in flight together.
//   - A read captured on the same edge as a write commit to the same register returns the OLD value.
// - REGn outputs update on the commit edge, i.e. they are visible 1 cycle after acceptance.
// - Reset mid-transaction: all handshakes abort and VALIDs drop immediately; registers clear to 0.
// CONFIGURATION
// - RFV_REG_UPD_EN defined:
//   - Adds port REG_UPD out [3:0], registered.
//   - REG_UPD[n] pulses high for exactly 1 cycle, the cycle after a write commit to register n.
//   - The pulse fires even when WSTRB=0. Reset value is 0.
// - RFV_REG_UPD_EN undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING
// - Write/readback test:
//   - Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0,0x4,0x8,0xC with WSTRB=F.
//   - Read each back: data matches, BRESP=RRESP=OKAY.
// - Partial strobe: REG1=0xABCD0001, then write 0x12345678 with WSTRB=4'b0101 -> readback 0xAB340078.
// - Skewed handshake: AWVALID 3 cycles before WVALID -> AWREADY and WREADY pulse together on the
//   first cycle both are high; one commit only.
// - Backpressure:
//   - BREADY held low 5 cycles -> BVALID stays 1 and a second write is not accepted.
//   - RREADY held low -> RDATA stable.
// - Collision: REG2=0x0, then read 0x8 and write 0x55AA55AA to 0x8 accepted on the same edge ->
//   RDATA=0x0, next read returns 0x55AA55AA.
// - Reset: assert ARESETN=0 while BVALID=1 -> BVALID=0 asynchronously, REG0..3=0.
//   With RFV_REG_UPD_EN, REG_UPD=0.

Source files
------------

// File: rtl/rangefinder_vga_axil_regs_if.sv
// ---------------------------------------------------------------------------
// rangefinder_vga_axil_regs_if
// AXI4-Lite bus bundle between the PS/BFM master and the rangefinder VGA
// register file.
//   master modport : drives AW/W/AR channels and B/R ready signals
//   slave  modport : drives AW/W/AR ready signals and B/R responses
// Signal names follow the S_AXI_* naming of the register-file slave port.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface rangefinder_vga_axil_regs_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [2:0]              S_AXI_AWPROT;
   logic                    S_AXI_AWVALID;
   logic                    S_AXI_AWREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                    S_AXI_WVALID;
   logic                    S_AXI_WREADY;
   logic [1:0]              S_AXI_BRESP;
   logic                    S_AXI_BVALID;
   logic                    S_AXI_BREADY;
   logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [2:0]              S_AXI_ARPROT;
   logic                    S_AXI_ARVALID;
   logic                    S_AXI_ARREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]              S_AXI_RRESP;
   logic                    S_AXI_RVALID;
   logic                    S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/rangefinder_vga_axil_regs.sv
// ---------------------------------------------------------------------------
// rangefinder_vga_axil_regs
// AXI4-Lite slave register file for the rangefinder VGA peripheral. Four
// read/write 32-bit registers at offsets 0x0/0x4/0x8/0xC (address bits [3:2]
// select, bits [1:0] ignored), exported straight from the flops.
// Ports:
//   ACLK         clock, rising edge
//   ARESETN      asynchronous active-low reset
//   s_axi        AXI4-Lite slave modport (rangefinder_vga_axil_regs_if)
//   REG0..REG3   current register contents
//   REG_UPD[3:0] one-cycle pulse per register after each write commit
//                (present only when RFV_REG_UPD_EN is defined)
// Optional feature macro: RFV_REG_UPD_EN
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module rangefinder_vga_axil_regs #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                   ACLK,
   input  logic                   ARESETN,
   rangefinder_vga_axil_regs_if.slave s_axi,
   output logic [DATA_WIDTH-1:0]  REG0,
   output logic [DATA_WIDTH-1:0]  REG1,
   output logic [DATA_WIDTH-1:0]  REG2,
   output logic [DATA_WIDTH-1:0]  REG3
`ifdef RFV_REG_UPD_EN
   ,
   output logic [3:0]             REG_UPD
`endif
);
   localparam int NBYTES = DATA_WIDTH / 8;

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

   wstate_t               w_state, w_next;
   rstate_t               r_state, r_next;
   logic                  wr_accept;
   logic [1:0]            wr_sel;
   logic [1:0]            rd_sel;
   logic [DATA_WIDTH-1:0] regs [4];
   logic [DATA_WIDTH-1:0] rd_data_p1;
   logic                  unused_ok;

   // Byte-lane merge: lanes with a strobe take the new data, others hold.
   function automatic logic [DATA_WIDTH-1:0] strb_merge(
      input logic [DATA_WIDTH-1:0] cur,
      input logic [DATA_WIDTH-1:0] wdat,
      input logic [NBYTES-1:0]     strb
   );
      logic [DATA_WIDTH-1:0] res;
      res = cur;
      for (int b = 0; b < NBYTES; b++) begin
         if (strb[b]) res[8*b +: 8] = wdat[8*b +: 8];
      end
      return res;
   endfunction

   assign wr_sel = s_axi.S_AXI_AWADDR[3:2];
   assign rd_sel = s_axi.S_AXI_ARADDR[3:2];

   // Protection bits and byte-offset address bits carry no meaning here.
   assign unused_ok = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

   // ---- write channel: accept AW+W together, then hold B until taken ----
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) w_state <= W_IDLE;
      else          w_state <= w_next;
   end

   // Ready is combinational so AW/W are taken on the first cycle both are
   // valid; gating with ARESETN keeps ready low while reset is held.
   always_comb begin
      w_next               = w_state;
      wr_accept            = 1'b0;
      s_axi.S_AXI_AWREADY  = 1'b0;
      s_axi.S_AXI_WREADY   = 1'b0;
      s_axi.S_AXI_BVALID   = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (ARESETN && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
               wr_accept           = 1'b1;
               s_axi.S_AXI_AWREADY = 1'b1;
               s_axi.S_AXI_WREADY  = 1'b1;
               w_next              = W_RESP;
            end
         end
         W_RESP: begin
            s_axi.S_AXI_BVALID = 1'b1;
            if (s_axi.S_AXI_BREADY) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   assign s_axi.S_AXI_BRESP = 2'b00;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else if (wr_accept) begin
         regs[wr_sel] <= strb_merge(regs[wr_sel], s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
      end
   end

   assign REG0 = regs[0];
   assign REG1 = regs[1];
   assign REG2 = regs[2];
   assign REG3 = regs[3];

`ifdef RFV_REG_UPD_EN
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)       REG_UPD <= 4'b0000;
      else if (wr_accept) REG_UPD <= 4'b0001 << wr_sel;
      else                REG_UPD <= 4'b0000;
   end
`endif

   // ---- read channel: registered ARREADY, data captured on that edge ----
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) r_state <= R_IDLE;
      else          r_state <= r_next;
   end

   always_comb begin
      r_next              = r_state;
      s_axi.S_AXI_ARREADY = 1'b0;
      s_axi.S_AXI_RVALID  = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (s_axi.S_AXI_ARVALID) r_next = R_ADDR;
         end
         R_ADDR: begin
            s_axi.S_AXI_ARREADY = 1'b1;
            r_next              = R_DATA;
         end
         R_DATA: begin
            s_axi.S_AXI_RVALID = 1'b1;
            if (s_axi.S_AXI_RREADY) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   // Capture uses the pre-edge register value, so a write committing on the
   // same edge is not visible to this read.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)              rd_data_p1 <= '0;
      else if (r_state == R_ADDR) rd_data_p1 <= regs[rd_sel];
   end

   assign s_axi.S_AXI_RDATA = rd_data_p1;
   assign s_axi.S_AXI_RRESP = 2'b00;
endmodule
